miriscv_apb_bridge: RTL and testbench
=====================================

# miriscv_apb_bridge

Two-phase APB master bridge between the core data port and the peripheral slaves (UART, timer). It replaces the single-cycle pseudo-APB decode with a compliant SETUP/ACCESS sequence. It waits on PREADY, reports PSLVERR, and decodes a one-hot PSEL per slave from the address. The bridge holds `busy_o` high while a transfer is in flight so the SoC can stall the core.

## Interface
Parameters:
- `XLEN`, 32, data and address width.
- `NSLV`, 2, number of APB slaves (1..8).
- `SEL_LSB`, 12, lowest address bit of the slave index field; the field is `$clog2(NSLV)` bits wide (1 bit if `NSLV`=1, ignored).
- `TIMEOUT`, 255, maximum ACCESS cycles with PREADY low before abort (only with `MIRISCV_APB_TIMEOUT_EN`).

Ports:
- `clk_i`  in  1  clock.
- `arstn_i`  in  1  reset, asynchronous, active-low.
- `data_req_i`  in  1  request; held stable with the request fields until `data_rvalid_o`.
- `data_we_i`  in  1  1 = write.
- `data_be_i`  in  XLEN/8  byte enables.
- `data_addr_i`  in  XLEN  byte address.
- `data_wdata_i`  in  XLEN  write data.
- `data_rvalid_o`  out  1  one-cycle completion pulse (reads and writes).
- `data_rdata_o`  out  XLEN  read data, valid with `data_rvalid_o`.
- `data_err_o`  out  1  error flag, valid with `data_rvalid_o`.
- `busy_o`  out  1  high in every state except IDLE.
- `psel_o`  out  NSLV  one-hot slave select.
- `penable_o`  out  1  APB enable.
- `pwrite_o`  out  1  APB write.
- `paddr_o`  out  XLEN  APB address (full byte address).
- `pwdata_o`  out  XLEN  APB write data.
- `pstrb_o`  out  XLEN/8  APB strobes; equal to `data_be_i` on writes, 0 on reads.
- `prdata_i`  in  NSLV*XLEN  flattened read data; slave k occupies `[k*XLEN +: XLEN]`.
- `pready_i`  in  NSLV  per-slave ready.
- `pslverr_i`  in  NSLV  per-slave error.

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - When `data_req_i`=1, the bridge registers `we`, `be`, `addr`, `wdata` and the slave index `idx = addr[SEL_LSB +: W]`.
  - If `idx` < NSLV, it moves to SETUP.
  - Otherwise it moves to RESP with err=1 and rdata=0. No APB cycle is issued.
- SETUP: `psel_o[idx]`=1, `penable_o`=0. Moves to ACCESS unconditionally.
- ACCESS:
  - `psel_o[idx]`=1 and `penable_o`=1.
  - When `pready_i[idx]`=1, the bridge captures `prdata_i[idx]` (captured as 0 on writes or when `pslverr_i[idx]`=1) and `pslverr_i[idx]`, then moves to RESP.
  - Otherwise it stays in ACCESS.
- RESP: `data_rvalid_o`=1 with the registered rdata and err. Returns to IDLE unconditionally.
- `data_req_i` is ignored in RESP. The requester drops or changes `req` in the cycle it sees `rvalid`.
- `paddr_o`, `pwrite_o`, `pwdata_o`, `pstrb_o` are driven from the registered request and hold through SETUP and ACCESS.
- Only the selected slave's `pready_i` and `pslverr_i` are observed; other bits are don't-care.

## Timing
- Reset values: every output is 0, `psel_o`=0, and the state is IDLE.
- Asserting `arstn_i` mid-transfer drops `psel_o`/`penable_o` immediately (asynchronously). The aborted transfer never produces `rvalid`.
- Latency with zero APB wait states:
  - request sampled at edge 0 → SETUP in cycle 1 → ACCESS in cycle 2 → RESP (`rvalid`) in cycle 3.
  - Each PREADY-low cycle adds 1.
- Out-of-range index: `rvalid` in cycle 1 after the sampling edge.
- Minimum request-to-request spacing is 4 cycles (IDLE, SETUP, ACCESS, RESP).
- `busy_o` is registered: high from cycle 1 through the RESP cycle.
- `data_rdata_o` and `data_err_o` are registered. They hold their last values outside RESP but are meaningful only while `rvalid` is high.

## Configuration
- `MIRISCV_APB_TIMEOUT_EN` defined:
  - An 8..16-bit counter clears on entry to ACCESS and increments on every ACCESS cycle with PREADY low.
  - When the counter reaches `TIMEOUT`, the bridge leaves ACCESS for RESP with err=1 and rdata=0. `psel_o`/`penable_o` drop in the RESP cycle.
  - A PREADY arriving in the same cycle as the limit takes priority: normal completion.
- `MIRISCV_APB_TIMEOUT_EN` undefined: no counter; ACCESS waits indefinitely. Errors come only from `pslverr_i` and out-of-range decode.

## Test plan
- Read from slave 1:
  - Stimulus: addr 0x8000_1004, pready=1 always, `prdata_i` slice 1 = 0x1234_5678.
  - Response: SETUP at cycle 1, ACCESS at cycle 2, `rvalid` at cycle 3 with rdata 0x1234_5678, err=0, `psel_o`=2'b10.
- Write to slave 0 with wait states:
  - Stimulus: addr 0x8000_0008, wdata 0xA5, be 4'b0001, pready low for 3 ACCESS cycles.
  - Response: `pstrb_o`=4'b0001 and `pwdata_o`=0xA5 stable for all 3 waits, `rvalid` at cycle 6, rdata=0.
- Slave error:
  - Stimulus: read with `pready`=1 and `pslverr`=1, `prdata` 0xFFFF_FFFF.
  - Response: `rvalid` with err=1, rdata=0.
- Out-of-range decode:
  - Stimulus: NSLV=3, index 3.
  - Response: `psel_o` stays 0, `rvalid` at cycle 1 with err=1.
- Reset in ACCESS:
  - Stimulus: drop `arstn_i` while `penable_o`=1.
  - Response: `psel_o`/`penable_o`/`busy_o` go to 0 in the same cycle, no `rvalid`, and the next request completes normally.
- With `MIRISCV_APB_TIMEOUT_EN`, TIMEOUT=4, pready held low:
  - Response: `rvalid` with err=1 after 4 ACCESS cycles.
  - With pready rising on the 4th cycle: normal completion, err=0.

Source files
------------

// File: rtl/miriscv_apb_bridge.sv
// miriscv_apb_bridge: two-phase APB master for the core data port; define MIRISCV_APB_TIMEOUT_EN to abort stalled ACCESS phases.
module miriscv_apb_bridge #(
  parameter int XLEN    = 32,
  parameter int NSLV    = 2,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  input  logic                 data_req_i,
  input  logic                 data_we_i,
  input  logic [XLEN/8-1:0]    data_be_i,
  input  logic [XLEN-1:0]      data_addr_i,
  input  logic [XLEN-1:0]      data_wdata_i,
  output logic                 data_rvalid_o,
  output logic [XLEN-1:0]      data_rdata_o,
  output logic                 data_err_o,
  output logic                 busy_o,
  output logic [NSLV-1:0]      psel_o,
  output logic                 penable_o,
  output logic                 pwrite_o,
  output logic [XLEN-1:0]      paddr_o,
  output logic [XLEN-1:0]      pwdata_o,
  output logic [XLEN/8-1:0]    pstrb_o,
  input  logic [NSLV*XLEN-1:0] prdata_i,
  input  logic [NSLV-1:0]      pready_i,
  input  logic [NSLV-1:0]      pslverr_i
);
  localparam int W  = NSLV > 1 ? $clog2(NSLV) : 1;
  localparam int BW = XLEN / 8;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;
  logic [1:0]      state_q, state_d;
  logic            we_q, we_d;
  logic [BW-1:0]   be_q, be_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [W-1:0]    idx_q, idx_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic [W-1:0]    req_idx;
  logic            in_range;
  logic            sel_ready;
  logic            sel_err;
  logic [XLEN-1:0] sel_rdata;
  logic            timeout;

  // with a single slave there is no index field, so every address maps to slave 0
  assign req_idx   = NSLV == 1 ? '0 : data_addr_i[SEL_LSB +: W];
  assign in_range  = {1'b0, req_idx} < (W+1)'(NSLV);
  assign sel_ready = pready_i[idx_q];
  assign sel_err   = pslverr_i[idx_q];
  assign sel_rdata = prdata_i[32'(idx_q)*XLEN +: XLEN];

`ifdef MIRISCV_APB_TIMEOUT_EN
  localparam int TW = TIMEOUT > 255 ? 16 : 8;
  logic [TW-1:0] cnt_q, cnt_d;

  // held at zero outside ACCESS so it is already clear on entry
  assign cnt_d   = state_q != ACCESS ? '0 : (sel_ready ? cnt_q : cnt_q + 1'b1);
  assign timeout = !sel_ready && cnt_q == TW'(TIMEOUT - 1);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (state_q == IDLE && data_req_i) begin
      we_d    = data_we_i;
      be_d    = data_be_i;
      addr_d  = data_addr_i;
      wdata_d = data_wdata_i;
      idx_d   = req_idx;
      state_d = in_range ? SETUP : RESP;
      if (!in_range) begin
        rdata_d = '0;
        err_d   = 1'b1;
      end
    end else if (state_q == SETUP) begin
      state_d = ACCESS;
    end else if (state_q == ACCESS && (sel_ready || timeout)) begin
      state_d = RESP;
      rdata_d = (we_q || !sel_ready || sel_err) ? '0 : sel_rdata;
      err_d   = !sel_ready || sel_err;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign data_rvalid_o = state_q == RESP;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;
  assign busy_o        = busy_q;
  assign psel_o        = (state_q == SETUP || state_q == ACCESS) ? NSLV'(1) << idx_q : '0;
  assign penable_o     = state_q == ACCESS;
  assign pwrite_o      = we_q;
  assign paddr_o       = addr_q;
  assign pwdata_o      = wdata_q;
  assign pstrb_o       = we_q ? be_q : '0;
endmodule

// File: tb/tb_miriscv_apb_bridge.sv
// tb_miriscv_apb_bridge: vector table, randomized transfers against a transaction-level model, reset and decode corner cases.
module tb_miriscv_apb_bridge;
  localparam int TMO = 4;
  logic clk = 1'b0;
  logic rst_n;
  logic req, we, req3;
  logic [3:0] be;
  logic [31:0] addr, wdata;
  logic rvalid, err, busy, penable, pwrite;
  logic [31:0] rdata, paddr, pwdata;
  logic [3:0] pstrb;
  logic [1:0] psel, pready, pslverr;
  logic [63:0] prdata;
  logic rvalid3, err3, busy3, penable3, pwrite3;
  logic [31:0] rdata3, paddr3, pwdata3;
  logic [3:0] pstrb3;
  logic [2:0] psel3, pready3, pslverr3;
  logic [95:0] prdata3;
  int checks = 0;
  int errors = 0;

  typedef struct {
    string name;
    logic we;
    logic [3:0] be;
    logic [31:0] addr, wdata, rd;
    int waits;
    logic slverr;
    int lat;
    logic [31:0] exp_rd;
    logic exp_err;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  miriscv_apb_bridge #(.XLEN(32), .NSLV(2), .SEL_LSB(12), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .arstn_i(rst_n), .data_req_i(req), .data_we_i(we), .data_be_i(be),
    .data_addr_i(addr), .data_wdata_i(wdata), .data_rvalid_o(rvalid), .data_rdata_o(rdata),
    .data_err_o(err), .busy_o(busy), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .paddr_o(paddr), .pwdata_o(pwdata), .pstrb_o(pstrb), .prdata_i(prdata),
    .pready_i(pready), .pslverr_i(pslverr));

  miriscv_apb_bridge #(.XLEN(32), .NSLV(3), .SEL_LSB(12), .TIMEOUT(TMO)) dut3 (
    .clk_i(clk), .arstn_i(rst_n), .data_req_i(req3), .data_we_i(we), .data_be_i(be),
    .data_addr_i(addr), .data_wdata_i(wdata), .data_rvalid_o(rvalid3), .data_rdata_o(rdata3),
    .data_err_o(err3), .busy_o(busy3), .psel_o(psel3), .penable_o(penable3), .pwrite_o(pwrite3),
    .paddr_o(paddr3), .pwdata_o(pwdata3), .pstrb_o(pstrb3), .prdata_i(prdata3),
    .pready_i(pready3), .pslverr_i(pslverr3));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // transaction-level expectation: latency, returned data and error flag
  function automatic void model(input logic w, input int waits, input logic slverr, input logic [31:0] rd,
                                output int lat, output logic [31:0] exp_rd, output logic exp_err);
    lat = 3 + waits;
    exp_err = slverr;
    exp_rd = (w || slverr) ? 32'h0 : rd;
`ifdef MIRISCV_APB_TIMEOUT_EN
    if (waits >= TMO) begin
      lat = 2 + TMO;
      exp_err = 1'b1;
      exp_rd = 32'h0;
    end
`endif
  endfunction

  task automatic run_txn(input string name, input logic w, input logic [3:0] b, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int waits, input logic slverr,
                         input int exp_lat, input logic [31:0] exp_rd, input logic exp_err);
    int idx, low, got_lat, viol;
    logic [31:0] got_rd;
    logic got_err;
    logic [1:0] exp_psel;
    idx = int'(a[12]);
    low = 0;
    got_lat = -1;
    viol = 0;
    got_rd = '0;
    got_err = 1'b0;
    @(negedge clk);
    req = 1'b1; we = w; be = b; addr = a; wdata = wd;
    prdata = {$urandom, $urandom};
    prdata[idx*32 +: 32] = rd;
    pready = 2'($urandom);
    pready[idx] = 1'b0;
    pslverr = 2'($urandom);
    @(posedge clk);
    for (int c = 1; c <= exp_lat + 16 && got_lat < 0; c++) begin
      @(negedge clk);
      exp_psel = (c >= 1 && c < exp_lat) ? 2'(1 << idx) : 2'b00;
      if (psel !== exp_psel) viol++;
      if (penable !== (c >= 2 && c < exp_lat)) viol++;
      if (busy !== 1'b1) viol++;
      if (psel != 2'b00 && (paddr !== a || pwrite !== w || pwdata !== wd || pstrb !== (w ? b : 4'h0))) viol++;
      if (rvalid) begin
        got_lat = c;
        got_rd = rdata;
        got_err = err;
        req = 1'b0;
      end
      pready = 2'($urandom);
      pslverr = 2'($urandom);
      if (penable) begin
        pready[idx] = (low == waits);
        if (low == waits) pslverr[idx] = slverr;
        if (low < waits) low++;
      end else begin
        pready[idx] = 1'b0;
      end
    end
    req = 1'b0;
    @(negedge clk);
    if (busy !== 1'b0 || rvalid !== 1'b0 || psel !== 2'b00) viol++;
    check({name, " latency"}, 32'(got_lat), 32'(exp_lat));
    check({name, " rdata"}, got_rd, exp_rd);
    check({name, " err"}, {31'b0, got_err}, {31'b0, exp_err});
    check({name, " protocol"}, 32'(viol), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, waits;
    logic w, se, got;
    logic [31:0] a, exp_rd, rd;
    logic exp_err;
    vecs[0] = '{"rd_slv1", 1'b0, 4'hF, 32'h8000_1004, 32'h0, 32'h1234_5678, 0, 1'b0, 3, 32'h1234_5678, 1'b0};
    vecs[1] = '{"wr_slv0_wait3", 1'b1, 4'b0001, 32'h8000_0008, 32'hA5, 32'hCAFE_F00D, 3, 1'b0, 6, 32'h0, 1'b0};
    vecs[2] = '{"rd_slverr", 1'b0, 4'hF, 32'h8000_1000, 32'h0, 32'hFFFF_FFFF, 0, 1'b1, 3, 32'h0, 1'b1};
    vecs[3] = '{"wr_slverr_wait1", 1'b1, 4'b1100, 32'h0000_1010, 32'h1111_2222, 32'h5555_AAAA, 1, 1'b1, 4, 32'h0, 1'b1};
    vecs[4] = '{"rd_slv0_wait2", 1'b0, 4'b0011, 32'h0000_0ffc, 32'h0, 32'hDEAD_BEEF, 2, 1'b0, 5, 32'hDEAD_BEEF, 1'b0};
    rst_n = 1'b0; req = 1'b0; req3 = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
    prdata = '0; pready = '0; pslverr = '0;
    prdata3 = {3{32'h7777_7777}}; pready3 = 3'b111; pslverr3 = 3'b000;
    repeat (2) @(negedge clk);
    check("reset psel", {30'b0, psel}, 32'h0);
    check("reset penable", {31'b0, penable}, 32'h0);
    check("reset busy", {31'b0, busy}, 32'h0);
    check("reset rvalid", {31'b0, rvalid}, 32'h0);
    check("reset paddr", paddr, 32'h0);
    check("reset pstrb", {28'b0, pstrb}, 32'h0);
    rst_n = 1'b1;
    foreach (vecs[i])
      run_txn(vecs[i].name, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, vecs[i].rd,
              vecs[i].waits, vecs[i].slverr, vecs[i].lat, vecs[i].exp_rd, vecs[i].exp_err);
`ifdef MIRISCV_APB_TIMEOUT_EN
    run_txn("timeout", 1'b0, 4'hF, 32'h8000_1020, 32'h0, 32'h1357_9BDF, TMO, 1'b0, 2 + TMO, 32'h0, 1'b1);
    run_txn("ready_at_limit", 1'b0, 4'hF, 32'h8000_1024, 32'h0, 32'h1357_9BDF, TMO - 1, 1'b0, 2 + TMO, 32'h1357_9BDF, 1'b0);
`endif
    for (int n = 0; n < 20; n++) begin
      w = 1'($urandom);
      a = $urandom;
      rd = $urandom;
      waits = $urandom_range(0, 5);
      se = ($urandom_range(0, 3) == 0);
      model(w, waits, se, rd, lat, exp_rd, exp_err);
      run_txn($sformatf("rand%0d", n), w, 4'($urandom), a, $urandom, rd, waits, se, lat, exp_rd, exp_err);
    end
    // out-of-range slave index on the three-slave bridge
    @(negedge clk);
    req3 = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h8000_3000;
    @(posedge clk);
    @(negedge clk);
    check("oor rvalid", {31'b0, rvalid3}, 32'h1);
    check("oor err", {31'b0, err3}, 32'h1);
    check("oor rdata", rdata3, 32'h0);
    check("oor psel", {29'b0, psel3}, 32'h0);
    check("oor busy", {31'b0, busy3}, 32'h1);
    req3 = 1'b0;
    @(negedge clk);
    check("oor idle", {30'b0, psel3, rvalid3}, 32'h0);
    // reset while in ACCESS
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h8000_0010; pready = 2'b00; pslverr = 2'b00;
    @(posedge clk);
    repeat (2) @(negedge clk);
    check("rst pre penable", {31'b0, penable}, 32'h1);
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst psel", {30'b0, psel}, 32'h0);
    check("rst penable", {31'b0, penable}, 32'h0);
    check("rst busy", {31'b0, busy}, 32'h0);
    got = 1'b0;
    repeat (3) begin
      @(negedge clk);
      got = got | rvalid;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      got = got | rvalid;
    end
    check("rst no rvalid", {31'b0, got}, 32'h0);
    run_txn("after_rst", 1'b0, 4'hF, 32'h8000_1004, 32'h0, 32'h0BAD_CAFE, 1, 1'b0, 4, 32'h0BAD_CAFE, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
